// File: rtl/ceespu_fetch_pkg.sv
// ceespu_fetch_pkg
//   Shared definitions for the ceespu instruction-fetch stage: widths,
//   the default boot vector and bubble encoding, and the fetch FSM states.
//   No ports (package).
package ceespu_fetch_pkg;

    localparam int PC_W    = 14;
    localparam int INSTR_W = 32;

    // Word address fetched first after reset
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 14'h0000;

    // ADD c0,c0,c0: no write-back, no memory access, no branch
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ceespu_fetch.sv
// ceespu_fetch
//   Instruction-fetch stage of the ceespu pipeline, directly upstream of decode.
//   Owns the program counter, drives a synchronous instruction memory with a
//   one-cycle read latency, and presents instruction / PC / justBranched to
//   decode combinationally. Handles branch redirects, decode stalls, memory
//   wait cycles and the reset boot vector.
// Ports
//   I_clk            in   1   clock, all state on posedge
//   I_rst            in   1   synchronous reset, active-high
//   I_stall          in   1   decode not accepting: hold current instruction/PC
//   I_branch         in   1   taken branch/jump/interrupt redirect from execute
//   I_branchAddress  in   14  redirect target (word address)
//   I_imem_data      in   32  imem read data for the address issued last cycle
//   I_imem_ready     in   1   I_imem_data valid this cycle
//   O_imem_addr      out  14  imem read address (combinational)
//   O_imem_en        out  1   imem read enable (always 1)
//   O_instruction    out  32  instruction to decode (NOP_INSTR when not valid)
//   O_PC             out  14  word address of O_instruction
//   O_valid          out  1   O_instruction is a real fetched instruction
//   O_justBranched   out  1   first valid instruction at a redirect target
module ceespu_fetch
    import ceespu_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_stall,
    input  logic               I_branch,
    input  logic [PC_W-1:0]    I_branchAddress,
    input  logic [INSTR_W-1:0] I_imem_data,
    input  logic               I_imem_ready,
    output logic [PC_W-1:0]    O_imem_addr,
    output logic               O_imem_en,
    output logic [INSTR_W-1:0] O_instruction,
    output logic [PC_W-1:0]    O_PC,
    output logic               O_valid,
    output logic               O_justBranched
);

    fetch_state_t        state, state_d;
    logic [PC_W-1:0]     fetch_pc, fetch_pc_d;
    logic [INSTR_W-1:0]  hold_q, hold_q_d;
    logic                hold_v, hold_v_d;
    logic [PC_W-1:0]     hold_pc, hold_pc_d;
    logic                hold_jb, hold_jb_d;
    logic                jb_q, jb_q_d;
    logic                stall_q, stall_q_d;

    logic                live_valid;
    logic [INSTR_W-1:0]  live_instr;
    logic                holding;
    logic [PC_W-1:0]     pc_inc;

    assign O_imem_en = 1'b1;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
            hold_q   <= NOP_INSTR;
            hold_v   <= 1'b0;
            hold_pc  <= RESET_PC;
            hold_jb  <= 1'b0;
            jb_q     <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state    <= state_d;
            fetch_pc <= fetch_pc_d;
            hold_q   <= hold_q_d;
            hold_v   <= hold_v_d;
            hold_pc  <= hold_pc_d;
            hold_jb  <= hold_jb_d;
            jb_q     <= jb_q_d;
            stall_q  <= stall_q_d;
        end
    end

    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        hold_q_d   = hold_q;
        hold_v_d   = hold_v;
        hold_pc_d  = hold_pc;
        hold_jb_d  = hold_jb;
        jb_q_d     = jb_q;
        stall_q_d  = stall_q;

        // Data arriving now belongs to fetch_pc; boot has nothing in flight yet
        live_valid = (state != S_BOOT) && I_imem_ready;
        live_instr = live_valid ? I_imem_data : NOP_INSTR;
        // Second and later stall cycles replay the captured item
        holding    = I_stall && stall_q;
        pc_inc     = fetch_pc + 14'd1;

        O_imem_addr    = fetch_pc;
        O_instruction  = live_instr;
        O_valid        = live_valid;
        O_PC           = fetch_pc;
        O_justBranched = jb_q && live_valid;

        if (I_rst) begin
            O_imem_addr    = RESET_PC;
            O_instruction  = NOP_INSTR;
            O_valid        = 1'b0;
            O_PC           = RESET_PC;
            O_justBranched = 1'b0;
        end else if (I_branch) begin
            // Squash whatever is presented and issue the target this cycle,
            // so the target reaches decode next cycle with no bubble
            O_instruction  = NOP_INSTR;
            O_valid        = 1'b0;
            O_justBranched = 1'b0;
            O_imem_addr    = I_branchAddress;
            fetch_pc_d     = I_branchAddress;
            hold_v_d       = 1'b0;
            jb_q_d         = 1'b1;
            stall_q_d      = 1'b0;
            state_d        = S_RUN;
        end else begin
            if (holding) begin
                O_instruction  = hold_q;
                O_valid        = hold_v;
                O_PC           = hold_pc;
                O_justBranched = hold_jb;
            end else if (I_stall) begin
                hold_q_d  = live_instr;
                hold_v_d  = live_valid;
                hold_pc_d = fetch_pc;
                hold_jb_d = jb_q && live_valid;
                stall_q_d = 1'b1;
            end else begin
                stall_q_d = 1'b0;
            end

            // A valid live item is either consumed by decode or parked in the
            // hold register, so the fetch moves on; the re-issued address during
            // the remaining stall cycles is then the instruction after the held one
            if (live_valid && !holding) begin
                O_imem_addr = pc_inc;
                fetch_pc_d  = pc_inc;
                jb_q_d      = 1'b0;
                state_d     = S_RUN;
            end else if (!I_stall) begin
                state_d = (state == S_BOOT) ? S_RUN : S_WAIT;
            end
        end
    end

endmodule

// File: tb/tb_ceespu_fetch.sv
// tb_ceespu_fetch
//   Self-checking bench for ceespu_fetch. Instruction memory is a synchronous
//   ROM with mem[i] = 32'hA000_0000 | i and a bench-controlled ready; while not
//   ready the data bus carries garbage. Each scenario task builds a table of
//   per-cycle stimulus plus expected outputs; the expectation is pushed to the
//   scoreboard when the stimulus is driven and popped when the outputs are sampled.
module tb_ceespu_fetch;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_stall = 1'b0;
    logic        I_branch = 1'b0;
    logic [13:0] I_branchAddress = 14'h0;
    logic [31:0] I_imem_data;
    logic        I_imem_ready = 1'b1;
    logic [13:0] O_imem_addr;
    logic        O_imem_en;
    logic [31:0] O_instruction;
    logic [13:0] O_PC;
    logic        O_valid;
    logic        O_justBranched;

    // ctl = {rst, stall, branch, not_ready}
    localparam logic [3:0] C_RUN  = 4'b0000;
    localparam logic [3:0] C_RST  = 4'b1000;
    localparam logic [3:0] C_STL  = 4'b0100;
    localparam logic [3:0] C_BR   = 4'b0010;
    localparam logic [3:0] C_NRDY = 4'b0001;
    // vj = {valid, justBranched}
    localparam logic [1:0] N  = 2'b00;
    localparam logic [1:0] V  = 2'b10;
    localparam logic [1:0] VJ = 2'b11;
    // ck = {check pc even when not valid, check imem addr}
    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_ADDR = 2'b01;
    localparam logic [1:0] K_BOTH = 2'b11;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [13:0] ba;
        logic [1:0]  vj;
        logic [13:0] pc;
        logic [1:0]  ck;
        logic [13:0] addr;
    } vec_t;

    vec_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    logic [13:0] rom_addr = 14'h0;

    ceespu_fetch dut (
        .I_clk           (I_clk),
        .I_rst           (I_rst),
        .I_stall         (I_stall),
        .I_branch        (I_branch),
        .I_branchAddress (I_branchAddress),
        .I_imem_data     (I_imem_data),
        .I_imem_ready    (I_imem_ready),
        .O_imem_addr     (O_imem_addr),
        .O_imem_en       (O_imem_en),
        .O_instruction   (O_instruction),
        .O_PC            (O_PC),
        .O_valid         (O_valid),
        .O_justBranched  (O_justBranched)
    );

    always #5 I_clk = ~I_clk;

    always @(posedge I_clk) rom_addr <= O_imem_addr;

    assign I_imem_data = I_imem_ready ? (32'hA000_0000 | {18'd0, rom_addr}) : 32'hDEAD_BEEF;

    function automatic vec_t row(input logic [3:0] ctl, input logic [13:0] ba,
                                 input logic [1:0] vj, input logic [13:0] pc,
                                 input logic [1:0] ck, input logic [13:0] addr);
        vec_t r;
        r.ctl = ctl; r.ba = ba; r.vj = vj; r.pc = pc; r.ck = ck; r.addr = addr;
        return r;
    endfunction

    task automatic apply(input vec_t r);
        @(posedge I_clk);
        #1;
        I_rst           = r.ctl[3];
        I_stall         = r.ctl[2];
        I_branch        = r.ctl[1];
        I_imem_ready    = !r.ctl[0];
        I_branchAddress = r.ba;
        sb.push_back(r);
        #3;
    endtask

    task automatic test_reset_boot();
        vec_t tbl[$];
        vec_t e;
        logic [31:0] ei;
        tbl.push_back(row(C_RST, 14'h0, N, 14'h0, K_BOTH, 14'h0));
        tbl.push_back(row(C_RUN, 14'h0, N, 14'h0, K_ADDR, 14'h0));
        tbl.push_back(row(C_RUN, 14'h0, V, 14'h0, K_ADDR, 14'h1));
        tbl.push_back(row(C_RUN, 14'h0, V, 14'h1, K_ADDR, 14'h2));
        tbl.push_back(row(C_RUN, 14'h0, V, 14'h2, K_NONE, 14'h0));
        tbl.push_back(row(C_RUN, 14'h0, V, 14'h3, K_NONE, 14'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            e  = sb.pop_front();
            ei = e.vj[1] ? (32'hA000_0000 | {18'd0, e.pc}) : 32'h0;
            n_vec++;
            if (O_valid !== e.vj[1] || O_justBranched !== e.vj[0] || O_instruction !== ei || O_imem_en !== 1'b1 ||
                ((e.vj[1] || e.ck[1]) && O_PC !== e.pc) || (e.ck[0] && O_imem_addr !== e.addr)) begin
                n_fail++;
                $display("[TB] FAIL reset_boot[%0d]: got valid=%b jb=%b instr=%h pc=%h addr=%h en=%b, want valid=%b jb=%b instr=%h pc=%h addr=%h",
                         i, O_valid, O_justBranched, O_instruction, O_PC, O_imem_addr, O_imem_en, e.vj[1], e.vj[0], ei, e.pc, e.addr);
            end
        end
    endtask

    task automatic test_stall_redirect();
        vec_t tbl[$];
        vec_t e;
        logic [31:0] ei;
        tbl.push_back(row(C_RUN, 14'h0,   V,  14'h4,   K_NONE, 14'h0));
        tbl.push_back(row(C_STL, 14'h0,   V,  14'h5,   K_NONE, 14'h0));
        tbl.push_back(row(C_STL, 14'h0,   V,  14'h5,   K_NONE, 14'h0));
        tbl.push_back(row(C_STL, 14'h0,   V,  14'h5,   K_NONE, 14'h0));
        tbl.push_back(row(C_RUN, 14'h0,   V,  14'h6,   K_NONE, 14'h0));
        tbl.push_back(row(C_RUN, 14'h0,   V,  14'h7,   K_NONE, 14'h0));
        tbl.push_back(row(C_BR,  14'h100, N,  14'h0,   K_ADDR, 14'h100));
        tbl.push_back(row(C_RUN, 14'h0,   VJ, 14'h100, K_NONE, 14'h0));
        tbl.push_back(row(C_RUN, 14'h0,   V,  14'h101, K_NONE, 14'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            e  = sb.pop_front();
            ei = e.vj[1] ? (32'hA000_0000 | {18'd0, e.pc}) : 32'h0;
            n_vec++;
            if (O_valid !== e.vj[1] || O_justBranched !== e.vj[0] || O_instruction !== ei || O_imem_en !== 1'b1 ||
                ((e.vj[1] || e.ck[1]) && O_PC !== e.pc) || (e.ck[0] && O_imem_addr !== e.addr)) begin
                n_fail++;
                $display("[TB] FAIL stall_redirect[%0d]: got valid=%b jb=%b instr=%h pc=%h addr=%h en=%b, want valid=%b jb=%b instr=%h pc=%h addr=%h",
                         i, O_valid, O_justBranched, O_instruction, O_PC, O_imem_addr, O_imem_en, e.vj[1], e.vj[0], ei, e.pc, e.addr);
            end
        end
    endtask

    task automatic test_wait_priority();
        vec_t tbl[$];
        vec_t e;
        logic [31:0] ei;
        // wait cycles at PC 9, then branch+stall priority
        tbl.push_back(row(C_BR,          14'h8,  N,  14'h0,  K_ADDR, 14'h8));
        tbl.push_back(row(C_RUN,         14'h0,  VJ, 14'h8,  K_NONE, 14'h0));
        tbl.push_back(row(C_NRDY,        14'h0,  N,  14'h0,  K_ADDR, 14'h9));
        tbl.push_back(row(C_NRDY,        14'h0,  N,  14'h0,  K_ADDR, 14'h9));
        tbl.push_back(row(C_RUN,         14'h0,  V,  14'h9,  K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,  V,  14'hA,  K_NONE, 14'h0));
        tbl.push_back(row(C_STL | C_BR,  14'h20, N,  14'h0,  K_ADDR, 14'h20));
        tbl.push_back(row(C_RUN,         14'h0,  VJ, 14'h20, K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,  V,  14'h21, K_NONE, 14'h0));
        // justBranched survives wait cycles on the target
        tbl.push_back(row(C_BR,          14'h40, N,  14'h0,  K_NONE, 14'h0));
        tbl.push_back(row(C_NRDY,        14'h0,  N,  14'h0,  K_NONE, 14'h0));
        tbl.push_back(row(C_NRDY,        14'h0,  N,  14'h0,  K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,  VJ, 14'h40, K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,  V,  14'h41, K_NONE, 14'h0));
        // justBranched survives a stall on the target
        tbl.push_back(row(C_BR,          14'h50, N,  14'h0,  K_NONE, 14'h0));
        tbl.push_back(row(C_STL,         14'h0,  VJ, 14'h50, K_NONE, 14'h0));
        tbl.push_back(row(C_STL,         14'h0,  VJ, 14'h50, K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,  V,  14'h51, K_NONE, 14'h0));
        // stall starting during a wait holds a bubble, nothing skipped
        tbl.push_back(row(C_NRDY,        14'h0,  N,  14'h0,  K_NONE, 14'h0));
        tbl.push_back(row(C_STL | C_NRDY,14'h0,  N,  14'h0,  K_NONE, 14'h0));
        tbl.push_back(row(C_STL,         14'h0,  N,  14'h0,  K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,  V,  14'h52, K_NONE, 14'h0));
        // branch during a wait, then back-to-back branches
        tbl.push_back(row(C_NRDY,        14'h0,  N,  14'h0,  K_NONE, 14'h0));
        tbl.push_back(row(C_BR | C_NRDY, 14'h60, N,  14'h0,  K_ADDR, 14'h60));
        tbl.push_back(row(C_BR,          14'h70, N,  14'h0,  K_ADDR, 14'h70));
        tbl.push_back(row(C_RUN,         14'h0,  VJ, 14'h70, K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,  V,  14'h71, K_NONE, 14'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            e  = sb.pop_front();
            ei = e.vj[1] ? (32'hA000_0000 | {18'd0, e.pc}) : 32'h0;
            n_vec++;
            if (O_valid !== e.vj[1] || O_justBranched !== e.vj[0] || O_instruction !== ei || O_imem_en !== 1'b1 ||
                ((e.vj[1] || e.ck[1]) && O_PC !== e.pc) || (e.ck[0] && O_imem_addr !== e.addr)) begin
                n_fail++;
                $display("[TB] FAIL wait_priority[%0d]: got valid=%b jb=%b instr=%h pc=%h addr=%h en=%b, want valid=%b jb=%b instr=%h pc=%h addr=%h",
                         i, O_valid, O_justBranched, O_instruction, O_PC, O_imem_addr, O_imem_en, e.vj[1], e.vj[0], ei, e.pc, e.addr);
            end
        end
    endtask

    task automatic test_wrap();
        vec_t tbl[$];
        vec_t e;
        logic [31:0] ei;
        tbl.push_back(row(C_BR,  14'h3FFF, N,  14'h0,    K_ADDR, 14'h3FFF));
        tbl.push_back(row(C_RUN, 14'h0,    VJ, 14'h3FFF, K_ADDR, 14'h0));
        tbl.push_back(row(C_RUN, 14'h0,    V,  14'h0,    K_ADDR, 14'h1));
        tbl.push_back(row(C_RUN, 14'h0,    V,  14'h1,    K_NONE, 14'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            e  = sb.pop_front();
            ei = e.vj[1] ? (32'hA000_0000 | {18'd0, e.pc}) : 32'h0;
            n_vec++;
            if (O_valid !== e.vj[1] || O_justBranched !== e.vj[0] || O_instruction !== ei || O_imem_en !== 1'b1 ||
                ((e.vj[1] || e.ck[1]) && O_PC !== e.pc) || (e.ck[0] && O_imem_addr !== e.addr)) begin
                n_fail++;
                $display("[TB] FAIL wrap[%0d]: got valid=%b jb=%b instr=%h pc=%h addr=%h en=%b, want valid=%b jb=%b instr=%h pc=%h addr=%h",
                         i, O_valid, O_justBranched, O_instruction, O_PC, O_imem_addr, O_imem_en, e.vj[1], e.vj[0], ei, e.pc, e.addr);
            end
        end
    endtask

    task automatic test_reset_midop();
        vec_t tbl[$];
        vec_t e;
        logic [31:0] ei;
        tbl.push_back(row(C_BR,          14'h200, N,  14'h0,   K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,   VJ, 14'h200, K_NONE, 14'h0));
        tbl.push_back(row(C_STL,         14'h0,   V,  14'h201, K_NONE, 14'h0));
        tbl.push_back(row(C_RST | C_STL, 14'h0,   N,  14'h0,   K_BOTH, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,   N,  14'h0,   K_ADDR, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,   V,  14'h0,   K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,   V,  14'h1,   K_NONE, 14'h0));
        tbl.push_back(row(C_RST | C_BR,  14'h300, N,  14'h0,   K_BOTH, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,   N,  14'h0,   K_ADDR, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,   V,  14'h0,   K_NONE, 14'h0));
        tbl.push_back(row(C_RUN,         14'h0,   V,  14'h1,   K_NONE, 14'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            e  = sb.pop_front();
            ei = e.vj[1] ? (32'hA000_0000 | {18'd0, e.pc}) : 32'h0;
            n_vec++;
            if (O_valid !== e.vj[1] || O_justBranched !== e.vj[0] || O_instruction !== ei || O_imem_en !== 1'b1 ||
                ((e.vj[1] || e.ck[1]) && O_PC !== e.pc) || (e.ck[0] && O_imem_addr !== e.addr)) begin
                n_fail++;
                $display("[TB] FAIL reset_midop[%0d]: got valid=%b jb=%b instr=%h pc=%h addr=%h en=%b, want valid=%b jb=%b instr=%h pc=%h addr=%h",
                         i, O_valid, O_justBranched, O_instruction, O_PC, O_imem_addr, O_imem_en, e.vj[1], e.vj[0], ei, e.pc, e.addr);
            end
        end
    endtask

    initial begin
        test_reset_boot();
        test_stall_redirect();
        test_wait_priority();
        test_wrap();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
